// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// State encoding and legal master-count limits.
package bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MIN_MASTERS = 2;
    localparam int MAX_MASTERS = 8;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner search: first eligible master after last_i,
// wrapping back to 0.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] elig_i,
    input  logic [SEL_WIDTH-1:0]   last_i,
    output logic                   found_o,
    output logic [SEL_WIDTH-1:0]   idx_o
);

    logic                 hi_found;
    logic                 lo_found;
    logic [SEL_WIDTH-1:0] hi_idx;
    logic [SEL_WIDTH-1:0] lo_idx;

    // Upper half (above last) has priority over the wrapped lower half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (elig_i[k] && (k > int'(last_i)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = SEL_WIDTH'(k);
            end
            if (elig_i[k] && (k <= int'(last_i)) && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = SEL_WIDTH'(k);
            end
        end
    end

    assign found_o = hi_found | lo_found;
    assign idx_o   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with split-transaction parking and
// priority resume of the parked master.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [SEL_WIDTH-1:0]   msel,
    output logic                   bus_busy,
    input  logic                   split_req,
    input  logic                   split_done,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic                   split_grant
);

    if (NUM_MASTERS < MIN_MASTERS || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
        $error("bus_arbiter_rr: NUM_MASTERS out of range");
    end

    arb_state_e state_q, state_d;

    logic [SEL_WIDTH-1:0]   last_q, last_d;
    logic [SEL_WIDTH-1:0]   owner_q, owner_d;
    logic                   split_valid_q, split_valid_d;
    logic                   resume_pend_q, resume_pend_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [SEL_WIDTH-1:0]   msel_q, msel_d;
    logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
    logic                   split_grant_q, split_grant_d;

    logic [NUM_MASTERS-1:0] park_mask;
    logic [NUM_MASTERS-1:0] elig;
    logic                   found;
    logic [SEL_WIDTH-1:0]   pick;
    logic                   in_idle;
    logic                   eff_resume;
    logic                   resume_go;
    logic                   resume_drop;
    logic                   rr_go;
    logic                   split_go;
    logic                   release_go;

    assign park_mask = split_valid_q ? (NUM_MASTERS'(1) << owner_q) : '0;
    assign elig      = breq & ~park_mask;

    rr_priority_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .SEL_WIDTH   (SEL_WIDTH)
    ) u_pick (
        .elig_i  (elig),
        .last_i  (last_q),
        .found_o (found),
        .idx_o   (pick)
    );

    // A done pulse seen in IDLE resumes straight away; in BUSY it latches.
    assign in_idle     = (state_q == ARB_IDLE);
    assign eff_resume  = split_valid_q & (resume_pend_q | split_done);
    assign resume_go   = in_idle & eff_resume & breq[owner_q];
    assign resume_drop = in_idle & eff_resume & ~breq[owner_q];
    assign rr_go       = in_idle & ~resume_go & found;
    assign split_go    = ~in_idle & split_req & ~split_valid_q;
    assign release_go  = ~in_idle & ~split_go & ~breq[msel_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (resume_go || rr_go) state_d = ARB_BUSY;
            ARB_BUSY: if (split_go || release_go) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        last_d        = last_q;
        owner_d       = owner_q;
        split_valid_d = split_valid_q;
        resume_pend_d = resume_pend_q;
        bgrant_d      = bgrant_q;
        msel_d        = msel_q;
        msplit_d      = '0;
        split_grant_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (resume_go || resume_drop) begin
                    split_valid_d = 1'b0;
                    resume_pend_d = 1'b0;
                end
                if (resume_go) begin
                    bgrant_d      = NUM_MASTERS'(1) << owner_q;
                    msel_d        = owner_q;
                    split_grant_d = 1'b1;
                end else if (rr_go) begin
                    bgrant_d = NUM_MASTERS'(1) << pick;
                    msel_d   = pick;
                    last_d   = pick;
                end
            end
            ARB_BUSY: begin
                if (split_done && split_valid_q) resume_pend_d = 1'b1;
                if (split_go) begin
                    owner_d       = msel_q;
                    split_valid_d = 1'b1;
                    msplit_d      = NUM_MASTERS'(1) << msel_q;
                    bgrant_d      = '0;
                end else if (release_go) begin
                    bgrant_d = '0;
                end
            end
            default: bgrant_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q        <= SEL_WIDTH'(NUM_MASTERS - 1);
            owner_q       <= '0;
            split_valid_q <= 1'b0;
            resume_pend_q <= 1'b0;
            bgrant_q      <= '0;
            msel_q        <= '0;
            msplit_q      <= '0;
            split_grant_q <= 1'b0;
        end else begin
            last_q        <= last_d;
            owner_q       <= owner_d;
            split_valid_q <= split_valid_d;
            resume_pend_q <= resume_pend_d;
            bgrant_q      <= bgrant_d;
            msel_q        <= msel_d;
            msplit_q      <= msplit_d;
            split_grant_q <= split_grant_d;
        end
    end

    assign bgrant      = bgrant_q;
    assign msel        = msel_q;
    assign bus_busy    = |bgrant_q;
    assign msplit      = msplit_q;
    assign split_grant = split_grant_q;

endmodule
